serial_mismatch_counter: RTL and testbench

- Bit-serial frame comparator that sits downstream of the mux-built XOR/XNOR gate stage.
- It drives operand bits a/b into an internal mux-based XOR stage and consumes the yxor result each accepted cycle.
- Per frame of FRAME_LEN bits it accumulates the Hamming distance, the running XOR parity and an all-equal flag, then reports them with a done pulse.
- Used by the Digithon gate-check harness to grade serial bit streams against expected streams.

---
 rtl/serial_mismatch_counter.sv | 118 +++++++++++
 tb/tb_serial_mismatch_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_mismatch_counter.sv
// Bit-serial frame comparator: counts a/b mismatches per FRAME_LEN-bit frame
// and reports Hamming distance, XOR parity and an all-equal flag with a done pulse.

module serial_mismatch_mux_xor (
  input  logic a,
  input  logic b,
  output logic yxor
);
  // XOR built from a 2:1 mux: a selects between b and its complement
  assign yxor = a ? ~b : b;
endmodule

// state | meaning
// IDLE  | waiting for start, ready = 1
// RUN   | accepting bit pairs, busy = 1
// DONE  | one-cycle done pulse, results just updated
module serial_mismatch_counter #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             a,
  input  logic             b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             parity,
  output logic             equal
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] work_cnt;
  logic             work_par;
  logic             yxor;
  logic [CNT_W-1:0] cnt_next;
  logic             par_next;
  logic             last_bit;

  serial_mismatch_mux_xor u_xor (
    .a    (a),
    .b    (b),
    .yxor (yxor)
  );

  assign cnt_next = work_cnt + CNT_W'(yxor);
  assign par_next = work_par ^ yxor;
  assign last_bit = (idx == LAST_IDX);

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      work_cnt     <= '0;
      work_par     <= 1'b0;
      mismatch_cnt <= '0;
      parity       <= 1'b0;
      equal        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            idx      <= '0;
            work_cnt <= '0;
            work_par <= 1'b0;
          end
        end
        RUN: begin
          // abort takes priority over a coincident final bit
          if (abort) begin
            state    <= IDLE;
            idx      <= '0;
            work_cnt <= '0;
            work_par <= 1'b0;
          end else if (bit_valid) begin
            if (last_bit) begin
              mismatch_cnt <= cnt_next;
              parity       <= par_next;
              equal        <= (cnt_next == '0);
              state        <= DONE;
              idx          <= '0;
              work_cnt     <= '0;
              work_par     <= 1'b0;
            end else begin
              idx      <= idx + IDX_W'(1);
              work_cnt <= cnt_next;
              work_par <= par_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mismatch_counter.sv
// Directed bench for serial_mismatch_counter: frames with hand-computed
// Hamming distance, parity, stalls, aborts, ignored inputs and async reset.

module tb_serial_mismatch_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, bit_valid, a, b;
  logic       ready, busy, done;
  logic [3:0] mismatch_cnt;
  logic       parity, equal;

  int vectors = 0;
  int errors  = 0;

  serial_mismatch_counter #(.FRAME_LEN(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .bit_valid    (bit_valid),
    .a            (a),
    .b            (b),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .mismatch_cnt (mismatch_cnt),
    .parity       (parity),
    .equal        (equal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame LSB first from IDLE. stall_x: bit index before which
  // stall_len idle cycles are inserted (-1 none). abort_at: bit index that
  // carries abort (-1 none). ign: drive inputs that must be ignored.
  task automatic run_frame(input string name, input logic [7:0] av, input logic [7:0] bv,
                           input int stall_x, input int stall_y, input int stall_len,
                           input int abort_at, input bit ign,
                           input logic [3:0] exp_cnt, input logic exp_par,
                           input logic exp_eq, input int exp_cyc);
    int cyc;
    start = 1'b1; bit_valid = ign; a = ign; b = 1'b0; abort = 1'b0;
    step(); cyc = 1;
    start = ign;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_x || i == stall_y) begin
        repeat (stall_len) begin
          bit_valid = 1'b0; a = 1'b1; b = 1'b0;
          step(); cyc++;
          vectors++;
          if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s stall: busy=%b done=%b, want busy=1 done=0", name, busy, done);
          end
        end
      end
      bit_valid = 1'b1; a = av[i]; b = bv[i]; abort = (i == abort_at);
      step(); cyc++;
      if (i == abort_at) begin
        abort = 1'b0; bit_valid = 1'b0; start = 1'b0;
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s abort state: ready=%b busy=%b done=%b, want 1 0 0", name, ready, busy, done);
        end
        vectors++;
        if (mismatch_cnt !== exp_cnt || parity !== exp_par || equal !== exp_eq) begin
          errors++;
          $display("FAIL %s abort results: cnt=%0d par=%b eq=%b, want %0d %b %b",
                   name, mismatch_cnt, parity, equal, exp_cnt, exp_par, exp_eq);
        end
        step();
        vectors++;
        if (done !== 1'b0 || ready !== 1'b1) begin
          errors++;
          $display("FAIL %s post-abort: done=%b ready=%b, want 0 1", name, done, ready);
        end
        return;
      end
      if (i < 7) begin
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s bit %0d: done=%b busy=%b, want 0 1", name, i, done, busy);
        end
      end
    end
    start = ign; bit_valid = ign; a = 1'b1; b = 1'b0;
    vectors++;
    if (done !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done cycle: done=%b ready=%b busy=%b, want 1 0 0", name, done, ready, busy);
    end
    vectors++;
    if (cyc + 1 !== exp_cyc) begin
      errors++;
      $display("FAIL %s latency: %0d cycles, want %0d", name, cyc + 1, exp_cyc);
    end
    vectors++;
    if (mismatch_cnt !== exp_cnt || parity !== exp_par || equal !== exp_eq) begin
      errors++;
      $display("FAIL %s results: cnt=%0d par=%b eq=%b, want %0d %b %b",
               name, mismatch_cnt, parity, equal, exp_cnt, exp_par, exp_eq);
    end
    step();
    start = 1'b0; bit_valid = 1'b0;
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: ready=%b busy=%b done=%b, want 1 0 0", name, ready, busy, done);
    end
    vectors++;
    if (mismatch_cnt !== exp_cnt || parity !== exp_par || equal !== exp_eq) begin
      errors++;
      $display("FAIL %s hold: cnt=%0d par=%b eq=%b, want %0d %b %b",
               name, mismatch_cnt, parity, equal, exp_cnt, exp_par, exp_eq);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bit_valid = 1'b0; a = 1'b0; b = 1'b0;
    repeat (2) step();
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        mismatch_cnt !== 4'd0 || parity !== 1'b0 || equal !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b busy=%b done=%b cnt=%0d par=%b eq=%b, want 1 0 0 0 0 0",
               ready, busy, done, mismatch_cnt, parity, equal);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset release: ready=%b busy=%b done=%b, want 1 0 0", ready, busy, done);
    end
  endtask

  task automatic test_frames();
    run_frame("a5_a5", 8'hA5, 8'hA5, -1, -1, 0, -1, 1'b0, 4'd0, 1'b0, 1'b1, 10);
    run_frame("ff_00", 8'hFF, 8'h00, -1, -1, 0, -1, 1'b0, 4'd8, 1'b0, 1'b0, 10);
    run_frame("01_00", 8'h01, 8'h00, -1, -1, 0, -1, 1'b0, 4'd1, 1'b1, 1'b0, 10);
  endtask

  task automatic test_stall();
    run_frame("a5_5a_stall", 8'hA5, 8'h5A, 2, 5, 3, -1, 1'b0, 4'd8, 1'b0, 1'b0, 16);
  endtask

  task automatic test_abort();
    run_frame("abort_ref", 8'h01, 8'h00, -1, -1, 0, -1, 1'b0, 4'd1, 1'b1, 1'b0, 10);
    run_frame("abort_mid", 8'hFF, 8'h00, -1, -1, 0, 4, 1'b0, 4'd1, 1'b1, 1'b0, 0);
    run_frame("abort_last", 8'hFF, 8'h00, -1, -1, 0, 7, 1'b0, 4'd1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_ignored();
    bit_valid = 1'b1; a = 1'b1; b = 1'b0; abort = 1'b1;
    repeat (3) step();
    bit_valid = 1'b0; abort = 1'b0;
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || mismatch_cnt !== 4'd1) begin
      errors++;
      $display("FAIL idle_ignore: ready=%b busy=%b cnt=%0d, want 1 0 1", ready, busy, mismatch_cnt);
    end
    run_frame("ignored_inputs", 8'h00, 8'h00, -1, -1, 0, -1, 1'b1, 4'd0, 1'b0, 1'b1, 10);
  endtask

  task automatic test_async_reset();
    run_frame("pre_reset", 8'h01, 8'h00, -1, -1, 0, -1, 1'b0, 4'd1, 1'b1, 1'b0, 10);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; a = 1'b1; b = 1'b0;
      step();
    end
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        mismatch_cnt !== 4'd0 || parity !== 1'b0 || equal !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ready=%b busy=%b done=%b cnt=%0d par=%b eq=%b, want 1 0 0 0 0 0",
               ready, busy, done, mismatch_cnt, parity, equal);
    end
    bit_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    run_frame("0f_00", 8'h0F, 8'h00, -1, -1, 0, -1, 1'b0, 4'd4, 1'b0, 1'b0, 10);
  endtask

  initial begin
    test_reset();
    test_frames();
    test_stall();
    test_abort();
    test_ignored();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
